// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: FSM encodings, default
// widths and the byte-length codes understood by the memory controller.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } arb_state_e;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

endpackage

// File: rtl/mem_arb_slot.sv
// One-entry holding register. Clear has priority over load so a flush or
// grant always wins over a same-cycle capture.
module mem_arb_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of the byte-serial memory controller: one slot
// per port, data-first priority with a starvation cap for pending fetches.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ARB_ADDR_W,
    parameter int DATA_W       = ARB_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_inst,
    input  logic              flush,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_len,
    input  logic              d_signed,
    output logic              d_ack,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mc_ifetch,
    output logic              mc_load,
    output logic              mc_save,
    output logic [ADDR_W-1:0] mc_iaddr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    output logic [2:0]        mc_len,
    output logic              mc_signed,
    input  logic              mc_inst_valid,
    input  logic [DATA_W-1:0] mc_inst,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int DS_W  = 1 + ADDR_W + DATA_W + 3 + 1;

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              drop_q, drop_d;
    logic              gnt_i, gnt_d, i_avail;

    logic              i_vld, d_vld;
    logic [ADDR_W-1:0] i_addr;
    logic [DS_W-1:0]   d_slot;
    logic              s_we, s_signed;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [2:0]        s_len;

    logic              if_valid_q, d_done_q, cur_we_q;
    logic              mc_ifetch_q, mc_load_q, mc_save_q, mc_signed_q;
    logic [DATA_W-1:0] if_inst_q, d_rdata_q, mc_wdata_q;
    logic [ADDR_W-1:0] mc_iaddr_q, mc_addr_q;
    logic [2:0]        mc_len_q;

    // A flushed fetch must not be granted in the same cycle it is cancelled.
    assign i_avail = i_vld & ~flush;
    assign if_ack  = if_req & ~i_vld & ~flush & ~gnt_i;
    assign d_ack   = d_req & ~d_vld & ~gnt_d;

    mem_arb_slot #(.W(ADDR_W)) u_islot (
        .clk(clk), .rst(rst), .load_i(if_ack), .clear_i(gnt_i | flush),
        .data_i(if_addr), .valid_o(i_vld), .data_o(i_addr)
    );

    mem_arb_slot #(.W(DS_W)) u_dslot (
        .clk(clk), .rst(rst), .load_i(d_ack), .clear_i(gnt_d),
        .data_i({d_we, d_addr, d_wdata, d_len, d_signed}),
        .valid_o(d_vld), .data_o(d_slot)
    );

    assign {s_we, s_addr, s_wdata, s_len, s_signed} = d_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (gnt_d) state_d = ST_WAIT_D;
                       else if (gnt_i) state_d = ST_WAIT_I;
            ST_WAIT_I: if (mc_inst_valid) state_d = ST_IDLE;
            ST_WAIT_D: if (mc_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d    = 1'b0;
        gnt_i    = 1'b0;
        starve_d = starve_q;
        drop_d   = drop_q;
        if (state_q == ST_IDLE) begin
            gnt_d = d_vld & (~i_avail | (starve_q != CNT_W'(STARVE_LIMIT)));
            gnt_i = i_avail & ~gnt_d;
        end
        if (gnt_i || !i_vld)
            starve_d = '0;
        else if (gnt_d && starve_q != CNT_W'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
        // Drop is armed only while a fetch is in flight; its completion retires it.
        if (state_q == ST_WAIT_I) begin
            if (mc_inst_valid)
                drop_d = 1'b0;
            else if (flush)
                drop_d = 1'b1;
        end else begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_ifetch_q <= 1'b0;
            mc_load_q   <= 1'b0;
            mc_save_q   <= 1'b0;
            mc_iaddr_q  <= '0;
            mc_addr_q   <= '0;
            mc_wdata_q  <= '0;
            mc_len_q    <= '0;
            mc_signed_q <= 1'b0;
            cur_we_q    <= 1'b0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
        end else begin
            mc_ifetch_q <= gnt_i;
            mc_load_q   <= gnt_d & ~s_we;
            mc_save_q   <= gnt_d & s_we;
            if (gnt_i)
                mc_iaddr_q <= i_addr;
            if (gnt_d) begin
                mc_addr_q   <= s_addr;
                mc_wdata_q  <= s_wdata;
                mc_len_q    <= s_len;
                mc_signed_q <= s_signed;
                cur_we_q    <= s_we;
            end
            d_done_q <= (state_q == ST_WAIT_D) & mc_done;
            if (state_q == ST_WAIT_D && mc_done)
                d_rdata_q <= cur_we_q ? '0 : mc_rdata;
            if_valid_q <= (state_q == ST_WAIT_I) & mc_inst_valid & ~drop_q & ~flush;
            if (state_q == ST_WAIT_I && mc_inst_valid && !drop_q && !flush)
                if_inst_q <= mc_inst;
        end
    end

    assign if_valid  = if_valid_q;
    assign if_inst   = if_inst_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign mc_ifetch = mc_ifetch_q;
    assign mc_load   = mc_load_q;
    assign mc_save   = mc_save_q;
    assign mc_iaddr  = mc_iaddr_q;
    assign mc_addr   = mc_addr_q;
    assign mc_wdata  = mc_wdata_q;
    assign mc_len    = mc_len_q;
    assign mc_signed = mc_signed_q;

endmodule
